mac_36_rr_sched: RTL

- Round-robin scheduler that shares one mac_36 datapath (out = a*b + c) between NUM_REQ requesters.
- Each requester has a valid/ready request channel; all requesters share one response channel tagged with the requester id.
- One output register gives the block a fixed 1-cycle latency and honours backpressure.
- Sits between the fabric-side requester logic and the single mapped MAC instance.

---
 rtl/mac_sched_pkg.sv | 66 ++++++
 rtl/mac_36.sv | 23 ++
 rtl/mac_36_rr_sched_rr_arbiter.sv | 38 +++
 rtl/mac_36_rr_sched.sv | 117 +++++++++++
 4 files changed

// File: rtl/mac_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mac_sched_pkg
//  Description : Shared types, constants and helper functions for the
//                round-robin MAC scheduler (mac_36_rr_sched).
//                - MAC_WIDTH  : default operand/result width of mac_36
//                - clog2      : ceiling log2 for id-width derivation
//                - rr_pick    : round-robin search returning {found, index}
//                - slot_state_t : EMPTY/FULL state of the response register
//  Revision    : 1.0 - initial release
// ============================================================================
package mac_sched_pkg;

    localparam int MAC_WIDTH = 4;
    // Largest supported requester count; rr_pick works on this fixed width.
    localparam int MAX_REQ   = 8;
    localparam int IDX_W     = 3;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    // First set bit of valid[n-1:0], searching upward from ptr with wrap.
    function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                      input int unsigned        ptr,
                                      input int unsigned        n);
        pick_t            r;
        int unsigned      j;
        logic [IDX_W-1:0] pos;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < MAX_REQ; k++) begin
            if (k < n) begin
                j = ptr + k;
                if (j >= n) begin
                    j = j - n;
                end
                pos = IDX_W'(j);
                if (!r.found && valid[pos]) begin
                    r.found = 1'b1;
                    r.idx   = pos;
                end
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mac_36.sv
`default_nettype none
// ============================================================================
//  Module      : mac_36
//  Description : Combinational unsigned multiply-accumulate,
//                out = (a*b + c) mod 2^WIDTH.
//  Ports       : a, b, c (in, WIDTH)  operands and addend
//                out     (out, WIDTH) truncated result
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_36 #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic [WIDTH-1:0] out
);

    // Evaluated in a WIDTH-bit context, so product and sum wrap naturally.
    assign out = a * b + c;

endmodule
`default_nettype wire

// File: rtl/mac_36_rr_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Combinational round-robin arbiter. Grants the first set bit
//                of req at or above ptr (with wrap) when enable is high.
//  Ports       : req    (in, NUM_REQ)  request vector
//                enable (in, 1)        grant allowed this cycle
//                ptr    (in, ID_W)     highest-priority index
//                grant  (out, NUM_REQ) one-hot grant, zero if none/disabled
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import mac_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant
);

    pick_t              pick;
    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req;
        pick                 = rr_pick(req_ext, 32'(ptr), NUM_REQ);
        grant                = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = enable && pick.found && (int'(pick.idx) == i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/mac_36_rr_sched.sv
`default_nettype none
// ============================================================================
//  Module      : mac_36_rr_sched
//  Description : Round-robin scheduler sharing one mac_36 between NUM_REQ
//                requesters. One response register gives a fixed 1-cycle
//                latency and full 1 op/cycle throughput under backpressure.
//  Ports       : clk, reset (sync, active-high)
//                req_valid/req_ready (NUM_REQ)  per-requester handshake
//                req_a/req_b/req_c (NUM_REQ*WIDTH) packed operands
//                rsp_valid/rsp_ready            shared response handshake
//                rsp_id (ID_W), rsp_data (WIDTH) response payload
//                op_count (CNT_W)               saturating accept counter
//  Revision    : 1.0 - initial release
// ============================================================================
module mac_36_rr_sched
    import mac_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = MAC_WIDTH,
    parameter int ID_W    = clog2(NUM_REQ),
    parameter int CNT_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ*WIDTH-1:0] req_c,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_data,
    output logic [CNT_W-1:0]         op_count
);

    slot_state_t        state;
    logic [ID_W-1:0]    ptr;
    logic [NUM_REQ-1:0] grant;
    logic               slot_free;
    logic               arb_en;
    logic               accept;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    ptr_next;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic [WIDTH-1:0]   sel_c;
    logic [WIDTH-1:0]   mac_out;

    assign rsp_valid = (state == FULL);
    assign slot_free = (state == EMPTY) || rsp_ready;
    // No grant during reset so no handshake can complete in that cycle.
    assign arb_en    = slot_free && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req    (req_valid),
        .enable (arb_en),
        .ptr    (ptr),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                gnt_idx = ID_W'(i);
            end
        end
    end

    assign ptr_next = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);

    assign sel_a = req_a[gnt_idx*WIDTH +: WIDTH];
    assign sel_b = req_b[gnt_idx*WIDTH +: WIDTH];
    assign sel_c = req_c[gnt_idx*WIDTH +: WIDTH];

    mac_36 #(
        .WIDTH (WIDTH)
    ) u_mac (
        .a   (sel_a),
        .b   (sel_b),
        .c   (sel_c),
        .out (mac_out)
    );

    // An accept always loads the register, even while draining, so a new
    // result replaces the old one in the same cycle without a bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= EMPTY;
            ptr      <= '0;
            rsp_id   <= '0;
            rsp_data <= '0;
            op_count <= '0;
        end else begin
            if (accept) begin
                state    <= FULL;
                rsp_id   <= gnt_idx;
                rsp_data <= mac_out;
                ptr      <= ptr_next;
                if (op_count != '1) begin
                    op_count <= op_count + CNT_W'(1);
                end
            end else if ((state == FULL) && rsp_ready) begin
                state <= EMPTY;
            end
        end
    end

endmodule
`default_nettype wire
